// File: rtl/inst_enc_if.sv
// Request/instruction stream bundle for the instruction encoder.
interface inst_enc_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_li;
  logic [2:0]      req_itype;
  logic [6:0]      req_opcode;
  logic [2:0]      req_funct3;
  logic [6:0]      req_funct7;
  logic [4:0]      req_rd;
  logic [4:0]      req_rs1;
  logic [4:0]      req_rs2;
  logic [XLEN-1:0] req_imm;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic            inst_last;
  logic            inst_err;

  modport master (
    output req_valid, req_li, req_itype, req_opcode,
    output req_funct3, req_funct7, req_rd, req_rs1,
    output req_rs2, req_imm, inst_ready,
    input  req_ready, inst_valid, inst, inst_last, inst_err
  );

  modport slave (
    input  req_valid, req_li, req_itype, req_opcode,
    input  req_funct3, req_funct7, req_rd, req_rs1,
    input  req_rs2, req_imm, inst_ready,
    output req_ready, inst_valid, inst, inst_last, inst_err
  );
endinterface

// File: rtl/inst_encoder.sv
// Field-level request to RV32/RV64 instruction word encoder,
// with LI pseudo-instruction expansion into LUI + ADDI(W).
module inst_encoder #(
  parameter int XLEN = 32
) (
  input logic       clock,
  input logic       reset,
  inst_enc_if.slave io
);
  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LI2    = (XLEN == 64) ? OP_IMM_32 : OP_IMM;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD1 = 2'd1;
  localparam logic [1:0] HOLD2 = 2'd2;

  localparam logic signed [XLEN-1:0] I_MIN = XLEN'(-2048);
  localparam logic signed [XLEN-1:0] I_MAX = XLEN'(2047);
  localparam logic signed [XLEN-1:0] B_MIN = XLEN'(-4096);
  localparam logic signed [XLEN-1:0] B_MAX = XLEN'(4094);
  localparam logic signed [XLEN-1:0] J_MIN = XLEN'(-1048576);
  localparam logic signed [XLEN-1:0] J_MAX = XLEN'(1048574);

  logic [1:0]  state;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] w2_q;
  logic        last_q;
  logic        err_q;

  logic [XLEN-1:0]        imm;
  logic signed [XLEN-1:0] simm;
  logic [XLEN-1:0]        sx;
  logic                   sx_bad;
  logic                   in_i;
  logic [31:0]            hi_sum;
  logic [4:0]             rd;

  logic [31:0] enc_w;
  logic [31:0] enc_w2;
  logic        enc_last;
  logic        enc_err;
  logic        accept;
  logic        consume;

  assign imm    = io.req_imm;
  assign simm   = $signed(imm);
  assign sx     = XLEN'($signed(imm[31:0]));
  assign sx_bad = (sx != imm);
  assign in_i   = (simm >= I_MIN) && (simm <= I_MAX);
  // Rounding: pre-add 0x800 so the sign-extended low part lands exactly.
  assign hi_sum = imm[31:0] + 32'h0000_0800;
  assign rd     = io.req_rd;

  always_comb begin
    enc_w    = '0;
    enc_w2   = '0;
    enc_last = 1'b1;
    enc_err  = 1'b0;
    if (io.req_li) begin
      if (in_i) begin
        enc_w = {imm[11:0], 5'd0, 3'd0, rd, OP_IMM};
      end else begin
        enc_w    = {hi_sum[31:12], rd, OP_LUI};
        enc_w2   = {imm[11:0], rd, 3'd0, rd, OP_LI2};
        enc_last = 1'b0;
        enc_err  = (XLEN == 64) && sx_bad;
      end
    end else begin
      case (io.req_itype)
        TYPE_R: enc_w = {io.req_funct7, io.req_rs2, io.req_rs1,
                         io.req_funct3, rd, io.req_opcode};
        TYPE_I: begin
          enc_w   = {imm[11:0], io.req_rs1, io.req_funct3,
                     rd, io.req_opcode};
          enc_err = !in_i;
        end
        TYPE_S: begin
          enc_w   = {imm[11:5], io.req_rs2, io.req_rs1,
                     io.req_funct3, imm[4:0], io.req_opcode};
          enc_err = !in_i;
        end
        TYPE_B: begin
          enc_w   = {imm[12], imm[10:5], io.req_rs2, io.req_rs1,
                     io.req_funct3, imm[4:1], imm[11], io.req_opcode};
          enc_err = (simm < B_MIN) || (simm > B_MAX) || imm[0];
        end
        TYPE_U: begin
          enc_w   = {imm[31:12], rd, io.req_opcode};
          enc_err = (imm[11:0] != 12'd0) || sx_bad;
        end
        TYPE_J: begin
          enc_w   = {imm[20], imm[10:1], imm[11], imm[19:12],
                     rd, io.req_opcode};
          enc_err = (simm < J_MIN) || (simm > J_MAX) || imm[0];
        end
        default: enc_err = 1'b1;
      endcase
    end
  end

  assign io.req_ready = (state == IDLE || (state == HOLD1 && last_q))
                        && (!valid_q || io.inst_ready);
  assign accept  = io.req_valid && io.req_ready;
  assign consume = valid_q && io.inst_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      inst_q  <= '0;
      w2_q    <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      state   <= HOLD1;
      valid_q <= 1'b1;
      inst_q  <= enc_w;
      w2_q    <= enc_w2;
      last_q  <= enc_last;
      err_q   <= enc_err;
    end else if (consume) begin
      if (state == HOLD1 && !last_q) begin
        state  <= HOLD2;
        inst_q <= w2_q;
        last_q <= 1'b1;
      end else begin
        state   <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end

  assign io.inst_valid = valid_q;
  assign io.inst       = inst_q;
  assign io.inst_last  = last_q;
  assign io.inst_err   = err_q;
endmodule
